rfc_forest_scheduler: RTL and testbench
=======================================

// Module: rfc_forest_scheduler
// PURPOSE
//  Sequences one shared tree-traversal engine across NUM_TREES decision trees of the random forest.
//  On start it launches each tree in turn (id 0..NUM_TREES-1), collects each 1-bit tree label and
//  accumulates the votes. It then emits the majority-vote class with a one-cycle done pulse.
//  Sits between the top-level control (start_traversal) and the per-tree traversal datapath.
// PARAMETERS
//  NUM_TREES    8    trees in the forest; 2..255
//  TREE_ID_W    3    width of eng_tree_id; must satisfy 2**TREE_ID_W >= NUM_TREES
//  TIMEOUT_CYC  64   max cycles in WAIT for eng_done before abort; 1..65535
//  TIE_LABEL    1    class emitted when ones*2 == NUM_TREES
// PORTS
//  clk          in   1          single clock, rising edge
//  reset        in   1          asynchronous, active-high; clears all state
//  start        in   1          request a classification; sampled only in IDLE
//  busy         out  1          high in every state except IDLE
//  eng_start    out  1          one-cycle launch pulse to the traversal engine
//  eng_tree_id  out  TREE_ID_W  tree selected for the engine; stable from LAUNCH through WAIT
//  eng_done     in   1          engine finished the current tree; sampled only in WAIT
//  eng_label    in   1          engine result; valid with eng_done
//  done         out  1          one-cycle pulse: final_label, vote_ones and error are valid
//  final_label  out  1          majority class; held until the next done
//  vote_ones    out  8          count of trees that voted 1; held until the next done
//  error        out  1          the last run aborted on timeout; held until the next done
// BEHAVIOUR
//  Reset: state=IDLE; busy, eng_start, done, final_label, error = 0; eng_tree_id, vote_ones = 0;
//   internal vote and timeout counters = 0. Reset mid-run aborts at once with no done pulse.
//  FSM (registered state; outputs decoded from state or registered):
//   IDLE   : start=1 -> clear votes, tree_id=0, go to LAUNCH. Other inputs ignored.
//   LAUNCH : eng_start=1 for this cycle only; clear timeout counter; -> WAIT.
//   WAIT   : on eng_done=1, add eng_label to votes.
//            If tree_id==NUM_TREES-1 -> DECIDE; else tree_id+1 -> LAUNCH.
//            With eng_done=0, increment timeout counter.
//            When the counter reaches TIMEOUT_CYC (first cycle it equals TIMEOUT_CYC with
//            eng_done still 0), go to DONE with error_next=1 and final_label_next=0.
//            eng_done takes priority over timeout in the same cycle.
//   DECIDE : ones*2 > NUM_TREES -> 1; ones*2 < NUM_TREES -> 0; equal -> TIE_LABEL.
//            Register final_label, vote_ones, error=0; -> DONE.
//   DONE   : done=1 for exactly one cycle; -> IDLE.
//  Output hold: outputs update only on entry to DONE.
//  Latency: zero-wait engine (eng_done in first WAIT cycle) -> done high 2*NUM_TREES+1 cycles after
//   the edge that samples start. Each engine wait cycle adds 1.
//  start while busy: ignored, not queued. start in the DONE cycle: ignored.
//   start in the first IDLE cycle after DONE: accepted.
//  eng_done outside WAIT: ignored, no vote change.
//  eng_done and eng_start are never in the same cycle, because eng_done is only seen from WAIT.
//  Vote counter is 8 bits and cannot overflow (NUM_TREES <= 255).
//  Vote arithmetic uses 9-bit compare.
// TESTING
//  1 8 trees, engine returns label=1 one cycle after each eng_start -> eng_tree_id 0..7 in order,
//    done at +17 cycles, final_label=1, vote_ones=8, error=0.
//  2 labels 1,0,1,0,1,0,1,0 (tie) -> final_label=TIE_LABEL(1), vote_ones=4.
//    Rerun with TIE_LABEL=0 -> final_label=0.
//  3 labels 0,0,1,0,0,1,0,0 with 3-cycle engine latency each -> final_label=0, vote_ones=2,
//    done at +33 cycles.
//  4 engine never asserts eng_done for tree 2 -> after 64 WAIT cycles: done=1, error=1,
//    final_label=0, busy=0 next cycle. Next good run clears error.
//  5 start pulsed during WAIT of tree 3, and eng_done pulsed in IDLE -> both ignored;
//    the run result is unchanged and only one done pulse occurs.
//  6 assert reset during WAIT of tree 5 -> same cycle: busy=0, eng_start=0, no done pulse;
//    outputs read 0; a fresh start completes normally.

Source files
------------

// File: rtl/rfc_forest_scheduler.sv
// Random-forest vote scheduler: launches each tree on the shared traversal engine,
// gathers the 1-bit labels, then reports the majority class with a one-cycle done pulse.
module rfc_forest_scheduler #(
  parameter int   NUM_TREES   = 8,
  parameter int   TREE_ID_W   = 3,
  parameter int   TIMEOUT_CYC = 64,
  parameter logic TIE_LABEL   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 eng_start,
  output logic [TREE_ID_W-1:0] eng_tree_id,
  input  logic                 eng_done,
  input  logic                 eng_label,
  output logic                 done,
  output logic                 final_label,
  output logic [7:0]           vote_ones,
  output logic                 error
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [TREE_ID_W-1:0] LAST_ID     = TREE_ID_W'(NUM_TREES - 1);
  localparam logic [TREE_ID_W-1:0] ID_ONE      = TREE_ID_W'(1'b1);
  localparam logic [8:0]           NUM_TREES_9 = 9'(NUM_TREES);
  localparam logic [16:0]          TIMEOUT_17  = 17'(TIMEOUT_CYC);

  logic [2:0]           state_r;
  logic [2:0]           state_s;
  logic [TREE_ID_W-1:0] tree_id_r;
  logic [TREE_ID_W-1:0] tree_id_s;
  logic [7:0]           vote_cnt_r;
  logic [7:0]           vote_cnt_s;
  logic [15:0]          timeout_cnt_r;
  logic [15:0]          timeout_cnt_s;
  logic [16:0]          timeout_inc_s;
  logic                 result_load_s;
  logic                 result_label_s;
  logic                 result_err_s;
  logic                 busy_r;
  logic                 eng_start_r;
  logic                 done_r;
  logic                 final_label_r;
  logic [7:0]           vote_ones_r;
  logic                 error_r;

  // Doubling the count keeps the comparison exact for odd and even forest sizes.
  function automatic logic majority(input logic [7:0] ones);
    logic [8:0] twice;
    twice = {ones, 1'b0};
    if (twice > NUM_TREES_9) begin
      majority = 1'b1;
    end else if (twice < NUM_TREES_9) begin
      majority = 1'b0;
    end else begin
      majority = TIE_LABEL;
    end
  endfunction

  assign timeout_inc_s = {1'b0, timeout_cnt_r} + 17'd1;

  // Next-state, vote accumulation and result selection.
  always_comb begin
    state_s        = state_r;
    tree_id_s      = tree_id_r;
    vote_cnt_s     = vote_cnt_r;
    timeout_cnt_s  = timeout_cnt_r;
    result_load_s  = 1'b0;
    result_label_s = 1'b0;
    result_err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_LAUNCH;
          vote_cnt_s = 8'd0;
          tree_id_s  = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        timeout_cnt_s = 16'd0;
        state_s       = ST_WAIT;
      end
      ST_WAIT: begin
        // A completing engine wins over a timeout that expires in the same cycle.
        if (eng_done) begin
          vote_cnt_s = vote_cnt_r + {7'd0, eng_label};
          if (tree_id_r == LAST_ID) begin
            state_s = ST_DECIDE;
          end else begin
            tree_id_s = tree_id_r + ID_ONE;
            state_s   = ST_LAUNCH;
          end
        end else if (timeout_inc_s == TIMEOUT_17) begin
          timeout_cnt_s  = timeout_inc_s[15:0];
          result_load_s  = 1'b1;
          result_label_s = 1'b0;
          result_err_s   = 1'b1;
          state_s        = ST_DONE;
        end else begin
          timeout_cnt_s = timeout_inc_s[15:0];
        end
      end
      ST_DECIDE: begin
        result_load_s  = 1'b1;
        result_label_s = majority(vote_cnt_r);
        result_err_s   = 1'b0;
        state_s        = ST_DONE;
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; results change only on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      tree_id_r     <= '0;
      vote_cnt_r    <= 8'd0;
      timeout_cnt_r <= 16'd0;
      busy_r        <= 1'b0;
      eng_start_r   <= 1'b0;
      done_r        <= 1'b0;
      final_label_r <= 1'b0;
      vote_ones_r   <= 8'd0;
      error_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      tree_id_r     <= tree_id_s;
      vote_cnt_r    <= vote_cnt_s;
      timeout_cnt_r <= timeout_cnt_s;
      busy_r        <= (state_s != ST_IDLE);
      eng_start_r   <= (state_s == ST_LAUNCH);
      done_r        <= (state_s == ST_DONE);
      if (result_load_s) begin
        final_label_r <= result_label_s;
        vote_ones_r   <= vote_cnt_r;
        error_r       <= result_err_s;
      end else begin
        final_label_r <= final_label_r;
        vote_ones_r   <= vote_ones_r;
        error_r       <= error_r;
      end
    end
  end

  assign busy        = busy_r;
  assign eng_start   = eng_start_r;
  assign eng_tree_id = tree_id_r;
  assign done        = done_r;
  assign final_label = final_label_r;
  assign vote_ones   = vote_ones_r;
  assign error       = error_r;

endmodule

// File: tb/tb_rfc_forest_scheduler.sv
// Bench for rfc_forest_scheduler: two instances (TIE_LABEL 1 and 0) share one stimulus,
// a timing/vote model predicts launches, busy, done and results for every cycle.
module tb_rfc_forest_scheduler;

  localparam int NT = 8;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       eng_done = 1'b0;
  logic       eng_label = 1'b0;
  logic       busy1, eng_start1, done1, fl1, err1;
  logic [2:0] id1;
  logic [7:0] votes1;
  logic       busy0, eng_start0, done0, fl0, err0;
  logic [2:0] id0;
  logic [7:0] votes0;

  rfc_forest_scheduler #(.NUM_TREES(NT), .TREE_ID_W(3), .TIMEOUT_CYC(TO), .TIE_LABEL(1'b1)) dut_t1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy1), .eng_start(eng_start1),
    .eng_tree_id(id1), .eng_done(eng_done), .eng_label(eng_label), .done(done1),
    .final_label(fl1), .vote_ones(votes1), .error(err1)
  );

  rfc_forest_scheduler #(.NUM_TREES(NT), .TREE_ID_W(3), .TIMEOUT_CYC(TO), .TIE_LABEL(1'b0)) dut_t0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy0), .eng_start(eng_start0),
    .eng_tree_id(id0), .eng_done(eng_done), .eng_label(eng_label), .done(done0),
    .final_label(fl0), .vote_ones(votes0), .error(err0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scenario tables: label and engine latency per tree (latency 0 = engine never answers)
  int lab_tab[NT];
  int lat_tab[NT];

  // model state
  int exp_launch[int];
  int done_c = -1;
  int busy_lo = 1;
  int busy_hi = 0;
  bit pend_fl1, pend_fl0, pend_err, pend_vv;
  int pend_votes;
  bit held_fl1 = 1'b0, held_fl0 = 1'b0, held_err = 1'b0, held_vv = 1'b1;
  int held_votes = 0;

  int n_cmp = 0;
  int n_fail = 0;
  int dn_cnt = 0;
  int last_done_cyc = -1;
  int s;
  int d0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit maj(input int ones, input bit tie);
    if (ones * 2 > NT) return 1'b1;
    else if (ones * 2 < NT) return 1'b0;
    else return tie;
  endfunction

  // Predict a whole run from its start cycle: each tree costs 1 launch cycle + its latency,
  // then one decide cycle; a silent engine ends the run TO wait cycles after its launch.
  task automatic plan(input int st);
    int c;
    int ones;
    bit err;
    c = st;
    ones = 0;
    err = 1'b0;
    exp_launch.delete();
    for (int t = 0; t < NT; t++) begin
      exp_launch[c] = t;
      if (lat_tab[t] == 0) begin
        err = 1'b1;
        break;
      end
      ones += lab_tab[t];
      c += lat_tab[t] + 1;
    end
    done_c     = err ? c + TO + 1 : c + 1;
    busy_lo    = st;
    busy_hi    = done_c;
    pend_err   = err;
    pend_fl1   = err ? 1'b0 : maj(ones, 1'b1);
    pend_fl0   = err ? 1'b0 : maj(ones, 1'b0);
    pend_votes = ones;
    pend_vv    = !err;
  endtask

  // the single per-cycle compare process
  always @(posedge clk) begin
    #1;
    if (exp_launch.exists(cyc)) begin
      chk("eng_start_t1", int'(eng_start1), 1);
      chk("eng_start_t0", int'(eng_start0), 1);
      chk("tree_id_t1", int'(id1), exp_launch[cyc]);
      chk("tree_id_t0", int'(id0), exp_launch[cyc]);
    end else begin
      chk("eng_start_t1", int'(eng_start1), 0);
      chk("eng_start_t0", int'(eng_start0), 0);
    end
    if (cyc == done_c) begin
      held_fl1   = pend_fl1;
      held_fl0   = pend_fl0;
      held_err   = pend_err;
      held_votes = pend_votes;
      held_vv    = pend_vv;
    end
    chk("done_t1", int'(done1), int'(cyc == done_c));
    chk("done_t0", int'(done0), int'(cyc == done_c));
    if (done1 === 1'b1) begin
      dn_cnt++;
      last_done_cyc = cyc;
    end
    chk("busy_t1", int'(busy1), int'(cyc >= busy_lo && cyc <= busy_hi));
    chk("busy_t0", int'(busy0), int'(cyc >= busy_lo && cyc <= busy_hi));
    chk("final_t1", int'(fl1), int'(held_fl1));
    chk("final_t0", int'(fl0), int'(held_fl0));
    chk("error_t1", int'(err1), int'(held_err));
    chk("error_t0", int'(err0), int'(held_err));
    if (held_vv) begin
      chk("votes_t1", int'(votes1), held_votes);
      chk("votes_t0", int'(votes0), held_votes);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    eng_done = 1'b0;
    eng_label = 1'b0;
    exp_launch.delete();
    done_c = -1;
    busy_lo = 1;
    busy_hi = 0;
    held_fl1 = 1'b0;
    held_fl0 = 1'b0;
    held_err = 1'b0;
    held_votes = 0;
    held_vv = 1'b1;
    #1;
    chk("rst_busy", int'(busy1), 0);
    chk("rst_busy_t0", int'(busy0), 0);
    chk("rst_eng_start", int'(eng_start1), 0);
    chk("rst_done", int'(done1), 0);
    chk("rst_final", int'(fl1), 0);
    chk("rst_votes", int'(votes1), 0);
    chk("rst_error", int'(err1), 0);
    chk("rst_tree_id", int'(id1), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (done1 === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) chk("done_seen", 0, 1);
  endtask

  // Runs one classification. b2b: called in the DONE cycle of the previous run, start is
  // raised there and held into the following IDLE cycle. inj: tree whose first WAIT cycle
  // also sees a stray start. rst_at: tree whose first WAIT cycle gets a reset.
  task automatic run(input bit b2b, input int inj, input int rst_at, output int st);
    bit stop;
    stop = 1'b0;
    if (!b2b) @(negedge clk);
    st = b2b ? cyc + 2 : cyc + 1;
    plan(st);
    start = 1'b1;
    if (b2b) @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < NT && !stop; t++) begin
      if (lat_tab[t] == 0) begin
        stop = 1'b1;
      end else begin
        for (int k = 1; k <= lat_tab[t] && !stop; k++) begin
          @(negedge clk);
          start = (t == inj && k == 1);
          if (t == rst_at && k == 1) begin
            do_reset();
            stop = 1'b1;
          end
        end
        if (!stop) begin
          eng_label = lab_tab[t][0];
          eng_done = 1'b1;
          @(negedge clk);
          eng_done = 1'b0;
          eng_label = 1'b0;
          start = 1'b0;
        end
      end
    end
    if (rst_at < 0) wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    do_reset();

    // all trees vote 1, zero-wait engine
    lab_tab = '{1, 1, 1, 1, 1, 1, 1, 1};
    lat_tab = '{1, 1, 1, 1, 1, 1, 1, 1};
    run(1'b0, -1, -1, s);
    chk("t1_latency", last_done_cyc - s, 17);
    chk("t1_votes", int'(votes1), 8);
    chk("t1_label", int'(fl1), 1);
    chk("t1_error", int'(err1), 0);

    // tie, start raised in the DONE cycle and held into IDLE
    lab_tab = '{1, 0, 1, 0, 1, 0, 1, 0};
    run(1'b1, -1, -1, s);
    chk("t2_latency", last_done_cyc - s, 17);
    chk("t2_label_tie1", int'(fl1), 1);
    chk("t2_label_tie0", int'(fl0), 0);
    chk("t2_votes", int'(votes1), 4);

    // minority of ones, 3-cycle engine latency
    lab_tab = '{0, 0, 1, 0, 0, 1, 0, 0};
    lat_tab = '{3, 3, 3, 3, 3, 3, 3, 3};
    run(1'b0, -1, -1, s);
    chk("t3_latency", last_done_cyc - s, 33);
    chk("t3_label", int'(fl1), 0);
    chk("t3_votes", int'(votes1), 2);

    // engine silent on tree 2
    lab_tab = '{1, 1, 1, 1, 1, 1, 1, 1};
    lat_tab = '{1, 1, 0, 1, 1, 1, 1, 1};
    run(1'b0, -1, -1, s);
    chk("t4_latency", last_done_cyc - s, 69);
    chk("t4_error", int'(err1), 1);
    chk("t4_label", int'(fl1), 0);
    @(negedge clk);
    chk("t4_busy_after", int'(busy1), 0);
    lab_tab = '{1, 1, 1, 0, 0, 1, 1, 0};
    lat_tab = '{1, 1, 1, 1, 1, 1, 1, 1};
    run(1'b0, -1, -1, s);
    chk("t4_error_cleared", int'(err1), 0);
    chk("t4_votes", int'(votes1), 5);
    chk("t4_label_good", int'(fl1), 1);

    // stray start during WAIT of tree 3, stray eng_done in IDLE
    lab_tab = '{0, 1, 1, 0, 1, 0, 0, 1};
    lat_tab = '{2, 2, 2, 2, 2, 2, 2, 2};
    d0 = dn_cnt;
    run(1'b0, 3, -1, s);
    chk("t5_latency", last_done_cyc - s, 25);
    @(negedge clk);
    eng_done = 1'b1;
    eng_label = 1'b1;
    repeat (2) @(negedge clk);
    eng_done = 1'b0;
    eng_label = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_done_count", dn_cnt - d0, 1);
    chk("t5_votes", int'(votes1), 4);
    chk("t5_label_tie1", int'(fl1), 1);
    chk("t5_label_tie0", int'(fl0), 0);

    // reset in WAIT of tree 5, then a fresh all-zero run
    lab_tab = '{1, 1, 1, 1, 1, 1, 1, 1};
    lat_tab = '{1, 1, 1, 1, 1, 3, 1, 1};
    d0 = dn_cnt;
    run(1'b0, -1, 5, s);
    chk("t6_no_done", dn_cnt - d0, 0);
    lab_tab = '{0, 0, 0, 0, 0, 0, 0, 0};
    lat_tab = '{1, 1, 1, 1, 1, 1, 1, 1};
    run(1'b0, -1, -1, s);
    chk("t6_latency", last_done_cyc - s, 17);
    chk("t6_votes", int'(votes1), 0);
    chk("t6_label", int'(fl1), 0);
    chk("t6_error", int'(err1), 0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
